// File: rtl/qq_pkg.sv
// ============================================================================
// Module      : qq_pkg
// Description : Shared types and helpers for the QuickQ host front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qq_pkg;

    localparam int c_QQ_W = 8;

    typedef enum logic [1:0] {
        ENQ  = 2'b00,
        DEQ  = 2'b01,
        REPL = 2'b10,
        RSVD = 2'b11
    } qq_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETTLE = 2'b01,
        RESP   = 2'b10
    } qq_front_state_t;

    typedef struct packed {
        qq_op_t              op;
        logic [c_QQ_W-1:0]   data;
    } qq_cmd_t;

    // A command is rejected when the node chain cannot legally perform it.
    function automatic logic qq_is_error(input qq_op_t op,
                                         input logic   node_full,
                                         input logic   node_empty);
        logic err;
        case (op)
            ENQ:       err = node_full;
            DEQ, REPL: err = node_empty;
            default:   err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

`default_nettype wire

// File: rtl/qq_cmd_fifo.sv
// ============================================================================
// Module      : qq_cmd_fifo
// Description : Small synchronous command FIFO with full/empty/count status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qq_cmd_fifo #(
    parameter int DW    = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [DW-1:0]              head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Entries are cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;

endmodule

`default_nettype wire

// File: rtl/qq_front.sv
// ============================================================================
// Module      : qq_front
// Description : Host command front end: buffers commands, issues them one at
//               a time to the queue node chain and returns one response each.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qq_front
    import qq_pkg::*;
#(
    parameter int W  = 8,
    parameter int FD = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err,
    output logic         enq_o,
    output logic         deq_o,
    output logic         repl_o,
    output logic [W-1:0] data_o,
    input  logic         rdy_i,
    input  logic         full_i,
    input  logic         empty_i,
    input  logic [W-1:0] data_i
);

    localparam int AW = $clog2(FD);
    localparam int CW = AW + 1;
    localparam int DW = W + 2;

    qq_front_state_t r_state;
    qq_front_state_t w_state_next;
    logic [W-1:0]    r_rsp_data;
    logic [W-1:0]    w_rsp_data_next;
    logic            r_rsp_err;
    logic            w_rsp_err_next;

    logic            w_push;
    logic            w_pop;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [CW-1:0]   w_fifo_count;
    logic [DW-1:0]   w_fifo_head;
    qq_op_t          w_head_op;
    logic [W-1:0]    w_head_data;

    assign cmd_ready = !w_fifo_full;
    assign w_push    = cmd_valid && cmd_ready;

    qq_cmd_fifo #(
        .DW    (DW),
        .DEPTH (FD)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({cmd_op, cmd_data}),
        .pop       (w_pop),
        .head_data (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    always_comb begin
        assert (w_fifo_full == (w_fifo_count == CW'(FD)));
    end

    assign w_head_op   = qq_op_t'(w_fifo_head[DW-1:W]);
    assign w_head_data = w_fifo_head[W-1:0];
    assign data_o      = w_head_data;

    always_comb begin
        w_state_next    = r_state;
        w_rsp_data_next = r_rsp_data;
        w_rsp_err_next  = r_rsp_err;
        w_pop           = 1'b0;
        enq_o           = 1'b0;
        deq_o           = 1'b0;
        repl_o          = 1'b0;
        case (r_state)
            IDLE: begin
                // Status inputs only matter in the cycle the head is popped.
                if (!w_fifo_empty && rdy_i) begin
                    w_pop = 1'b1;
                    if (qq_is_error(w_head_op, full_i, empty_i)) begin
                        w_rsp_err_next  = 1'b1;
                        w_rsp_data_next = '0;
                        w_state_next    = RESP;
                    end else begin
                        w_rsp_err_next  = 1'b0;
                        w_rsp_data_next = (w_head_op == ENQ) ? w_head_data : data_i;
                        enq_o           = (w_head_op == ENQ);
                        deq_o           = (w_head_op == DEQ);
                        repl_o          = (w_head_op == REPL);
                        w_state_next    = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (rdy_i) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rsp_data <= w_rsp_data_next;
            r_rsp_err  <= w_rsp_err_next;
        end
    end

    assign rsp_valid = (r_state == RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_qq_front.sv
// ============================================================================
// Module      : tb_qq_front
// Description : Self-checking bench for qq_front: transaction-level model plus
//               directed vectors with hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qq_front;

    localparam int W  = 8;
    localparam int FD = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_err;
    logic         enq_o;
    logic         deq_o;
    logic         repl_o;
    logic [W-1:0] data_o;
    logic         rdy_i;
    logic         full_i;
    logic         empty_i;
    logic [W-1:0] data_i;

    qq_front #(.W(W), .FD(FD)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .enq_o     (enq_o),
        .deq_o     (deq_o),
        .repl_o    (repl_o),
        .data_o    (data_o),
        .rdy_i     (rdy_i),
        .full_i    (full_i),
        .empty_i   (empty_i),
        .data_i    (data_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_hs     = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] data;
    } cmd_s;

    cmd_s         m_q[$];
    bit           m_busy;         // a command has been issued and not yet answered
    bit           m_answer;       // its response is being presented to the host
    logic [W-1:0] m_rsp_data;
    logic         m_rsp_err;

    always @(negedge clk) begin
        bit           exp_ready;
        bit           issue;
        bit           bad;
        logic [2:0]   exp_strobe;
        cmd_s         head;
        if (chk_en) begin
            if (!rst) begin
                chk("rst_cmd_ready", cmd_ready, 1);
                chk("rst_strobes", {enq_o, deq_o, repl_o}, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_err", rsp_err, 0);
                chk("rst_rsp_data", rsp_data, 0);
                chk("rst_data_o", data_o, 0);
                m_q.delete();
                m_busy   = 1'b0;
                m_answer = 1'b0;
            end else begin
                exp_ready  = (m_q.size() < FD);
                issue      = !m_busy && (m_q.size() > 0) && rdy_i;
                bad        = 1'b0;
                exp_strobe = 3'b000;
                if (issue) begin
                    head = m_q[0];
                    bad  = (head.op == 2'b11) || (head.op == 2'b00 && full_i) ||
                           (head.op != 2'b00 && empty_i);
                    if (!bad) begin
                        exp_strobe = (head.op == 2'b00) ? 3'b100 :
                                     (head.op == 2'b01) ? 3'b010 : 3'b001;
                    end
                end
                chk("cmd_ready", cmd_ready, exp_ready);
                chk("strobes", {enq_o, deq_o, repl_o}, exp_strobe);
                chk("rsp_valid", rsp_valid, m_answer);
                if (m_answer) begin
                    chk("rsp_data", rsp_data, m_rsp_data);
                    chk("rsp_err", rsp_err, m_rsp_err);
                end
                if (m_q.size() > 0) begin
                    chk("data_o", data_o, m_q[0].data);
                end
                // Advance to what the coming rising edge does.
                if (m_answer) begin
                    if (rsp_ready) begin
                        m_answer = 1'b0;
                        m_busy   = 1'b0;
                        n_hs++;
                    end
                end else if (m_busy && rdy_i) begin
                    m_answer = 1'b1;
                end
                if (issue) begin
                    void'(m_q.pop_front());
                    m_busy     = 1'b1;
                    m_answer   = bad;
                    m_rsp_err  = bad;
                    m_rsp_data = bad ? '0 : ((head.op == 2'b00) ? head.data : data_i);
                end
                if (cmd_valid && exp_ready) begin
                    m_q.push_back('{op: cmd_op, data: cmd_data});
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the command was accepted (the issue cycle).
    task automatic send(input logic [1:0] op, input logic [W-1:0] d);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        chk("send_accept_timeout", (n < 100), 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int hs0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        rdy_i     = 1'b1;
        full_i    = 1'b0;
        empty_i   = 1'b0;
        data_i    = 8'h11;
        rst       = 1'b1;
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        repeat (3) tick();
        chk("init_cmd_ready", cmd_ready, 1);
        chk("init_rsp_valid", rsp_valid, 0);
        chk("init_data_o", data_o, 0);
        rst = 1'b1;
        tick();

        // ENQ 0x25: strobe at t+1, response at t+3
        send(2'b00, 8'h25);
        chk("enq_strobe", enq_o, 1);
        chk("enq_data_o", data_o, 8'h25);
        tick();
        chk("enq_strobe_gone", enq_o, 0);
        chk("enq_rsp_early", rsp_valid, 0);
        tick();
        chk("enq_rsp_valid", rsp_valid, 1);
        chk("enq_rsp_data", rsp_data, 8'h25);
        chk("enq_rsp_err", rsp_err, 0);
        handshake();

        // DEQ returning head 0x07
        data_i = 8'h07;
        send(2'b01, 8'hEE);
        chk("deq_strobe", deq_o, 1);
        tick();
        tick();
        chk("deq_rsp_valid", rsp_valid, 1);
        chk("deq_rsp_data", rsp_data, 8'h07);
        chk("deq_rsp_err", rsp_err, 0);
        handshake();

        // DEQ on empty chain: error at t+2
        empty_i = 1'b1;
        send(2'b01, 8'h00);
        chk("deq_empty_strobes", {enq_o, deq_o, repl_o}, 0);
        tick();
        chk("deq_empty_rsp_valid", rsp_valid, 1);
        chk("deq_empty_rsp_err", rsp_err, 1);
        chk("deq_empty_rsp_data", rsp_data, 0);
        handshake();
        empty_i = 1'b0;

        // Five back-to-back ENQs with responses blocked
        for (int i = 1; i <= 5; i++) begin
            send(2'b00, 8'(i));
        end
        chk("b2b_cmd_ready_low", cmd_ready, 0);
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            if (rsp_valid) begin
                chk("b2b_order", rsp_data, 8'(got + 1));
                got++;
            end
            tick();
        end
        rsp_ready = 1'b0;
        chk("b2b_count", got, 5);

        // REPL 0x40 with node not ready for four SETTLE cycles
        data_i = 8'h33;
        send(2'b10, 8'h40);
        chk("repl_strobe", repl_o, 1);
        chk("repl_data_o", data_o, 8'h40);
        tick();
        rdy_i  = 1'b0;
        data_i = 8'h99;
        for (int i = 0; i < 4; i++) begin
            chk("repl_settle_hold", rsp_valid, 0);
            tick();
        end
        rdy_i = 1'b1;
        chk("repl_settle_last", rsp_valid, 0);
        tick();
        chk("repl_rsp_valid", rsp_valid, 1);
        chk("repl_rsp_data", rsp_data, 8'h33);
        handshake();

        // Reserved opcode and ENQ into a full chain
        send(2'b11, 8'hAA);
        chk("rsvd_strobes", {enq_o, deq_o, repl_o}, 0);
        tick();
        chk("rsvd_rsp_err", rsp_err, 1);
        chk("rsvd_rsp_data", rsp_data, 0);
        handshake();
        full_i = 1'b1;
        send(2'b00, 8'h5A);
        chk("full_strobes", {enq_o, deq_o, repl_o}, 0);
        tick();
        chk("full_rsp_valid", rsp_valid, 1);
        chk("full_rsp_err", rsp_err, 1);
        handshake();
        full_i = 1'b0;

        // Twelve mixed commands to wrap the FIFO pointers
        hs0       = n_hs;
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            data_i = 8'(8'h80 + i);
            send(2'(i % 3), 8'(8'hC0 + i));
        end
        repeat (50) tick();
        rsp_ready = 1'b0;
        chk("wrap_responses", n_hs - hs0, 12);

        // Reset mid-stream: one response pending, three commands buffered
        for (int i = 0; i < 4; i++) begin
            send(2'b00, 8'(8'h10 + i));
        end
        chk("pre_rst_rsp_valid", rsp_valid, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_data_o", data_o, 0);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_strobes", {enq_o, deq_o, repl_o}, 0);
            chk("post_rst_rsp_valid", rsp_valid, 0);
            chk("post_rst_cmd_ready", cmd_ready, 1);
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
